// File: rtl/fp_add_pipe.sv
// Pipelined FP32 adder: result = ax + ay, three enabled cycles after the operands are registered.
// Optional macro FP_ADD_RNE_EN selects round-to-nearest-even; by default the result is truncated.
module fp_add_pipe (
  input  logic        clk,
  input  logic        clr,
  input  logic        ena,
  input  logic        in_valid,
  input  logic [31:0] ax,
  input  logic [31:0] ay,
  output logic [31:0] result,
  output logic        out_valid
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  function automatic logic [23:0] round_rne(input logic [26:0] m);
    round_rne = {1'b0, m[25:3]} + {23'd0, m[2] & (m[1] | m[0] | m[3])};
  endfunction

  // Out-of-range exponents saturate to signed inf or flush to signed zero
  function automatic logic [31:0] sat_pack(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] f);
    if (e >= 10'sd255)   sat_pack = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0) sat_pack = {s, 31'd0};
    else                  sat_pack = {s, e[7:0], f};
  endfunction

  logic [31:0] r_ax_p0, r_ay_p0;
  logic        r_vld_p0;

  // ---- p0: operand capture
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ax_p0 <= '0; r_ay_p0 <= '0; r_vld_p0 <= 1'b0;
    end else if (ena) begin
      r_ax_p0 <= ax; r_ay_p0 <= ay; r_vld_p0 <= in_valid;
    end
  end

  logic [7:0]  w_ex, w_ey, w_ea, w_eb, w_diff;
  logic [22:0] w_fx, w_fy, w_fa, w_fb;
  logic        w_sx, w_sy, w_swap, w_sa, w_sb;
  logic        w_xnan, w_ynan, w_xinf, w_yinf, w_xzero, w_yzero, w_spec;
  logic [4:0]  w_sh;
  logic [49:0] w_bext;
  logic [26:0] w_ma, w_mb;
  logic [31:0] w_specv;

  assign w_sx    = r_ax_p0[31];
  assign w_sy    = r_ay_p0[31];
  assign w_ex    = r_ax_p0[30:23];
  assign w_ey    = r_ay_p0[30:23];
  assign w_fx    = (w_ex == 8'd0) ? 23'd0 : r_ax_p0[22:0];
  assign w_fy    = (w_ey == 8'd0) ? 23'd0 : r_ay_p0[22:0];
  assign w_xnan  = (w_ex == 8'hFF) && (w_fx != 23'd0);
  assign w_ynan  = (w_ey == 8'hFF) && (w_fy != 23'd0);
  assign w_xinf  = (w_ex == 8'hFF) && (w_fx == 23'd0);
  assign w_yinf  = (w_ey == 8'hFF) && (w_fy == 23'd0);
  assign w_xzero = (w_ex == 8'd0);
  assign w_yzero = (w_ey == 8'd0);
  assign w_spec  = w_xnan | w_ynan | w_xinf | w_yinf | (w_xzero & w_yzero);

  always_comb begin
    w_specv = {w_sx & w_sy, 31'd0};
    if (w_xnan || w_ynan || (w_xinf && w_yinf && (w_sx != w_sy))) w_specv = 32'h7FC00000;
    else if (w_xinf) w_specv = {w_sx, 8'hFF, 23'd0};
    else if (w_yinf) w_specv = {w_sy, 8'hFF, 23'd0};
  end

  assign w_swap = {w_ey, w_fy} > {w_ex, w_fx};
  assign w_sa   = w_swap ? w_sy : w_sx;
  assign w_sb   = w_swap ? w_sx : w_sy;
  assign w_ea   = w_swap ? w_ey : w_ex;
  assign w_eb   = w_swap ? w_ex : w_ey;
  assign w_fa   = w_swap ? w_fy : w_fx;
  assign w_fb   = w_swap ? w_fx : w_fy;
  assign w_diff = w_ea - w_eb;
  assign w_sh   = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
  // B is widened so every bit shifted past the round position lands in the sticky OR
  assign w_bext = {(w_eb != 8'd0), w_fb, 26'd0} >> w_sh;
  assign w_ma   = {(w_ea != 8'd0), w_fa, 3'b000};
  assign w_mb   = {w_bext[49:24], |w_bext[23:0]};

  logic        r_sign_p1, r_sub_p1, r_spec_p1, r_vld_p1;
  logic [7:0]  r_exp_p1;
  logic [26:0] r_ma_p1, r_mb_p1;
  logic [31:0] r_specv_p1;

  // ---- p1: unpacked, swapped and aligned
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sign_p1 <= 1'b0; r_sub_p1 <= 1'b0; r_spec_p1 <= 1'b0; r_vld_p1 <= 1'b0;
      r_exp_p1 <= '0; r_ma_p1 <= '0; r_mb_p1 <= '0; r_specv_p1 <= '0;
    end else if (ena) begin
      r_sign_p1 <= w_sa; r_sub_p1 <= w_sa ^ w_sb; r_spec_p1 <= w_spec; r_vld_p1 <= r_vld_p0;
      r_exp_p1 <= w_ea; r_ma_p1 <= w_ma; r_mb_p1 <= w_mb; r_specv_p1 <= w_specv;
    end
  end

  logic        r_sign_p2, r_spec_p2, r_vld_p2;
  logic [7:0]  r_exp_p2;
  logic [27:0] r_sum_p2;
  logic [31:0] r_specv_p2;

  // ---- p2: mantissa add/subtract
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sign_p2 <= 1'b0; r_spec_p2 <= 1'b0; r_vld_p2 <= 1'b0;
      r_exp_p2 <= '0; r_sum_p2 <= '0; r_specv_p2 <= '0;
    end else if (ena) begin
      r_sign_p2 <= r_sign_p1; r_spec_p2 <= r_spec_p1; r_vld_p2 <= r_vld_p1;
      r_exp_p2 <= r_exp_p1; r_specv_p2 <= r_specv_p1;
      r_sum_p2 <= r_sub_p1 ? ({1'b0, r_ma_p1} - {1'b0, r_mb_p1})
                           : ({1'b0, r_ma_p1} + {1'b0, r_mb_p1});
    end
  end

  logic [4:0]         w_lz;
  logic [26:0]        w_norm;
  logic signed [9:0]  w_exp_n, w_exp_r;
  logic [22:0]        w_frac_r;
  logic [31:0]        w_packed;

  assign w_lz = lzc27(r_sum_p2[26:0]);

  always_comb begin
    if (r_sum_p2[27]) begin
      w_norm  = {r_sum_p2[27:2], r_sum_p2[1] | r_sum_p2[0]};
      w_exp_n = $signed({2'b00, r_exp_p2}) + 10'sd1;
    end else begin
      w_norm  = r_sum_p2[26:0] << w_lz;
      w_exp_n = $signed({2'b00, r_exp_p2}) - $signed({5'd0, w_lz});
    end
  end

`ifdef FP_ADD_RNE_EN
  logic [23:0] w_rnd;
  logic        w_unused;
  assign w_rnd    = round_rne(w_norm);
  // A carry out of the fraction means the mantissa rolled over to 1.0 of the next binade
  assign w_exp_r  = w_rnd[23] ? (w_exp_n + 10'sd1) : w_exp_n;
  assign w_frac_r = w_rnd[22:0];
  assign w_unused = w_norm[26];
`else
  logic w_unused;
  assign w_exp_r  = w_exp_n;
  assign w_frac_r = w_norm[25:3];
  assign w_unused = ^{w_norm[26], w_norm[2:0], round_rne(27'd0)};
`endif

  assign w_packed = (r_sum_p2 == 28'd0) ? 32'h00000000
                                        : sat_pack(r_sign_p2, w_exp_r, w_frac_r);

  logic [31:0] r_result_p3;
  logic        r_vld_p3;

  // ---- p3: normalized, rounded and packed result
  always_ff @(posedge clk) begin
    if (clr) begin
      r_result_p3 <= '0; r_vld_p3 <= 1'b0;
    end else if (ena) begin
      r_result_p3 <= r_spec_p2 ? r_specv_p2 : w_packed;
      r_vld_p3    <= r_vld_p2;
    end
  end

  assign result    = r_result_p3;
  assign out_valid = r_vld_p3;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe; inputs change on the falling edge, outputs are read there too.
module tb_fp_add_pipe;
  logic        clk, clr, ena, in_valid;
  logic [31:0] ax, ay, result;
  logic        out_valid;
  int          n_cmp, n_err;

  fp_add_pipe dut (
    .clk(clk), .clr(clr), .ena(ena), .in_valid(in_valid),
    .ax(ax), .ay(ay), .result(result), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single pair through an otherwise idle pipeline; returns the output two and three edges later.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic v_mid, output logic [31:0] r, output logic v);
    @(negedge clk); clr = 0; ena = 1; in_valid = 1; ax = a; ay = b;
    @(negedge clk); in_valid = 0; ax = 0; ay = 0;
    @(negedge clk);
    @(negedge clk); v_mid = out_valid;
    @(negedge clk); r = result; v = out_valid;
  endtask

  task automatic test_reset();
    @(negedge clk); clr = 1; ena = 1; in_valid = 1; ax = 32'h3F57CEC0; ay = 32'h41591270;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (result !== 32'h0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset[%0d]: result=%h valid=%b required 00000000/0", i, result, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_t [3] = '{32'h3F57CEC0, 32'hBE126F00, 32'h3FE374C0};
    logic [31:0] b_t [3] = '{32'h41591270, 32'h41439DB4, 32'h414D0624};
    logic [31:0] e_t [3] = '{32'h41668F5C, 32'h414153F8, 32'h416974BC};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clr = 0; ena = 1; in_valid = 1; ax = a_t[i]; ay = b_t[i];
    end
    @(negedge clk); in_valid = 0; ax = 0; ay = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_early: valid=%b required 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (result !== e_t[i] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b[%0d]: result=%h valid=%b required %h/1", i, result, out_valid, e_t[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_tail: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_specials();
    logic [31:0] a_t [8] = '{32'h7F800000, 32'h7F7FFFFF, 32'h41668F5C, 32'h00000001,
                             32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h80800001};
    logic [31:0] b_t [8] = '{32'hFF800000, 32'h7F7FFFFF, 32'hC1668F5C, 32'h3F800000,
                             32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00800000};
    logic [31:0] e_t [8] = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h3F800000,
                             32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000};
    logic        vm, v;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      do_op(a_t[i], b_t[i], vm, r, v);
      n_cmp++;
      if (r !== e_t[i] || v !== 1'b1 || vm !== 1'b0) begin
        n_err++;
        $display("FAIL special[%0d] %h+%h: result=%h valid=%b early=%b required %h/1/0",
                 i, a_t[i], b_t[i], r, v, vm, e_t[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic        vm, v;
    logic [31:0] r, exp_r;
`ifdef FP_ADD_RNE_EN
    exp_r = 32'h3F800001;
`else
    exp_r = 32'h3F800000;
`endif
    do_op(32'h3F800000, 32'h33C00000, vm, r, v);
    n_cmp++;
    if (r !== exp_r || v !== 1'b1) begin
      n_err++; $display("FAIL rounding: result=%h valid=%b required %h/1", r, v, exp_r);
    end
  endtask

  task automatic test_stall();
    @(negedge clk); clr = 0; ena = 1; in_valid = 1; ax = 32'h3F800000; ay = 32'h3F800000;
    @(negedge clk); ena = 0; ax = 32'h41200000; ay = 32'h41200000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (result !== 32'h0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: result=%h valid=%b required 00000000/0", i, result, out_valid);
      end
    end
    ena = 1; in_valid = 0; ax = 0; ay = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_early: valid=%b required 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (result !== 32'h40000000 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_out: result=%h valid=%b required 40000000/1", result, out_valid);
    end
  endtask

  task automatic test_midflight_clr();
    logic [31:0] a_t [3] = '{32'h3F57CEC0, 32'hBE126F00, 32'h3FE374C0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clr = 0; ena = 1; in_valid = 1; ax = a_t[i]; ay = 32'h41591270;
    end
    @(negedge clk); clr = 1; ax = 32'h3F800000; ay = 32'h3F800000;
    @(negedge clk); clr = 0;
    n_cmp++;
    if (result !== 32'h0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL clr_flush: result=%h valid=%b required 00000000/0", result, out_valid);
    end
    @(negedge clk); in_valid = 0; ax = 0; ay = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL clr_discard[%0d]: valid=%b required 0", i, out_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (result !== 32'h40000000 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL clr_next: result=%h valid=%b required 40000000/1", result, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL clr_tail: valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clr = 1; ena = 0; in_valid = 0; ax = 0; ay = 0;
    test_reset();
    test_back_to_back();
    test_specials();
    test_rounding();
    test_stall();
    test_midflight_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
